// File: rtl/md_checker.sv
// rtl/md_checker.sv - metadata pattern stream checker with optional backpressure
// Beat k must carry (k+1) mod 256 in every byte lane; the compare is pipelined one stage.
module md_checker #(
    parameter int DW          = 512,
    parameter int STALL_EVERY = 0,
    parameter int LW          = $clog2(DW/8)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [31:0]   beats_expected,
    input  logic [DW-1:0] axis_tdata,
    input  logic          axis_tvalid,
    output logic          axis_tready,
    output logic [31:0]   beat_count,
    output logic [31:0]   error_count,
    output logic [31:0]   first_err_beat,
    output logic [LW-1:0] first_err_lane,
    output logic [7:0]    first_err_data,
    output logic          done,
    output logic          pass
);

    localparam int NB = DW / 8;
    localparam int TW = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;
    localparam logic [TW-1:0] THR_LAST = TW'((STALL_EVERY > 1) ? STALL_EVERY - 1 : 0);
    localparam bit STALL_EN = (STALL_EVERY > 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [TW-1:0]  r_thr;
    logic [31:0]    r_beats_exp;
    logic [31:0]    r_beat_cnt;
    logic [31:0]    r_err_cnt;
    logic [31:0]    r_feb;
    logic [LW-1:0]  r_fel;
    logic [7:0]     r_fed;
    logic           r_err_seen;
    logic [7:0]     r_exp;

    logic           r_s1_valid;
    logic [DW-1:0]  r_s1_data;
    logic [7:0]     r_s1_exp;
    logic [31:0]    r_s1_beat;

    logic           w_start_ok;
    logic           w_stall;
    logic           w_hs;
    logic           w_last_beat;
    logic [NB-1:0]  w_mis;
    logic           w_any_mis;
    logic [LW-1:0]  w_lane;
    logic [7:0]     w_lane_byte;

    assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_stall     = STALL_EN && (r_thr == THR_LAST);
    assign axis_tready = (r_state == S_RUN) && !w_stall;
    assign w_hs        = axis_tvalid && axis_tready;
    // 33-bit sum so a saturated beat count can never alias a programmed length.
    assign w_last_beat = (r_beats_exp != 32'd0) &&
                         (({1'b0, r_beat_cnt} + 33'd1) == {1'b0, r_beats_exp});

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_hs && w_last_beat) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  if (start) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Scan downwards so the lowest mismatching lane wins.
    always_comb begin
        w_mis       = '0;
        w_lane      = '0;
        w_lane_byte = 8'd0;
        for (int i = 0; i < NB; i++) begin
            w_mis[i] = (r_s1_data[8*i +: 8] != r_s1_exp);
        end
        for (int i = NB - 1; i >= 0; i--) begin
            if (w_mis[i]) begin
                w_lane      = LW'(i);
                w_lane_byte = r_s1_data[8*i +: 8];
            end
        end
        w_any_mis = |w_mis;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_thr       <= '0;
            r_beats_exp <= 32'd0;
            r_beat_cnt  <= 32'd0;
            r_err_cnt   <= 32'd0;
            r_feb       <= 32'd0;
            r_fel       <= '0;
            r_fed       <= 8'd0;
            r_err_seen  <= 1'b0;
            r_exp       <= 8'd1;
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_exp    <= 8'd0;
            r_s1_beat   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_thr       <= '0;
                r_beats_exp <= beats_expected;
                r_beat_cnt  <= 32'd0;
                r_err_cnt   <= 32'd0;
                r_feb       <= 32'd0;
                r_fel       <= '0;
                r_fed       <= 8'd0;
                r_err_seen  <= 1'b0;
                r_exp       <= 8'd1;
                r_s1_valid  <= 1'b0;
            end else begin
                if (r_state == S_RUN) begin
                    r_thr <= (r_thr == THR_LAST) ? '0 : r_thr + 1'b1;
                end

                r_s1_valid <= w_hs;
                if (w_hs) begin
                    r_s1_data <= axis_tdata;
                    r_s1_exp  <= r_exp;
                    r_s1_beat <= r_beat_cnt;
                    r_exp     <= r_exp + 8'd1;
                    if (r_beat_cnt != 32'hFFFF_FFFF) begin
                        r_beat_cnt <= r_beat_cnt + 32'd1;
                    end
                end

                // Stage 2 retires regardless of FSM state so DRAIN sees the last beat.
                if (r_s1_valid && w_any_mis) begin
                    if (r_err_cnt != 32'hFFFF_FFFF) begin
                        r_err_cnt <= r_err_cnt + 32'd1;
                    end
                    if (!r_err_seen) begin
                        r_err_seen <= 1'b1;
                        r_feb      <= r_s1_beat;
                        r_fel      <= w_lane;
                        r_fed      <= w_lane_byte;
                    end
                end
            end
        end
    end

    assign beat_count     = r_beat_cnt;
    assign error_count    = r_err_cnt;
    assign first_err_beat = r_feb;
    assign first_err_lane = r_fel;
    assign first_err_data = r_fed;
    assign done           = (r_state == S_DONE);
    assign pass           = (r_state == S_DONE) && (r_err_cnt == 32'd0);

endmodule

// File: tb/tb_md_checker.sv
// tb/tb_md_checker.sv - randomized self-checking bench for md_checker
// Two instances: one with no throttle, one stalling every 4th RUN cycle.
module tb_md_checker;

    localparam int DW = 64;
    localparam int NB = DW / 8;
    localparam int LW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 resetn;
    logic [1:0]           start;
    logic [1:0][31:0]     bexp;
    logic [1:0][DW-1:0]   tdata;
    logic [1:0]           tvalid;
    logic [1:0]           tready;
    logic [1:0][31:0]     bc;
    logic [1:0][31:0]     ec;
    logic [1:0][31:0]     feb;
    logic [1:0][LW-1:0]   fel;
    logic [1:0][7:0]      fed;
    logic [1:0]           done;
    logic [1:0]           pass;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         beat;
        int         lane;
        logic [7:0] val;
    } corr_t;
    corr_t corr[$];

    md_checker #(.DW(DW), .STALL_EVERY(0)) u_dut0 (
        .clk(clk), .resetn(resetn), .start(start[0]), .beats_expected(bexp[0]),
        .axis_tdata(tdata[0]), .axis_tvalid(tvalid[0]), .axis_tready(tready[0]),
        .beat_count(bc[0]), .error_count(ec[0]), .first_err_beat(feb[0]),
        .first_err_lane(fel[0]), .first_err_data(fed[0]), .done(done[0]), .pass(pass[0])
    );

    md_checker #(.DW(DW), .STALL_EVERY(4)) u_dut4 (
        .clk(clk), .resetn(resetn), .start(start[1]), .beats_expected(bexp[1]),
        .axis_tdata(tdata[1]), .axis_tvalid(tvalid[1]), .axis_tready(tready[1]),
        .beat_count(bc[1]), .error_count(ec[1]), .first_err_beat(feb[1]),
        .first_err_lane(fel[1]), .first_err_data(fed[1]), .done(done[1]), .pass(pass[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int stall_of(input int sel);
        return (sel == 1) ? 4 : 0;
    endfunction

    function automatic logic [DW-1:0] beat_data(input int k);
        logic [DW-1:0] d;
        for (int l = 0; l < NB; l++) d[8*l +: 8] = 8'((k + 1) % 256);
        foreach (corr[i]) if (corr[i].beat == k) d[8*corr[i].lane +: 8] = corr[i].val;
        return d;
    endfunction

    task automatic check_idle_zero(input int sel, input string name);
        check($sformatf("%s.tready", name), 32'(tready[sel]), 0);
        check($sformatf("%s.beats", name), bc[sel], 0);
        check($sformatf("%s.errs", name), ec[sel], 0);
        check($sformatf("%s.feb", name), feb[sel], 0);
        check($sformatf("%s.fel", name), 32'(fel[sel]), 0);
        check($sformatf("%s.fed", name), 32'(fed[sel]), 0);
        check($sformatf("%s.done", name), 32'(done[sel]), 0);
        check($sformatf("%s.pass", name), 32'(pass[sel]), 0);
    endtask

    // nexp=0 runs free for stop_after beats; reset_at>0 aborts with a reset after that many beats.
    task automatic do_run(input int sel, input int nexp, input int pct, input int stop_after,
                          input int restart_at, input int reset_at, input string name);
        int   k = 0, cyc = 0, errs = 0, fbeat = 0, flane = 0, fdata = 0;
        int   limit, st;
        bit   seen = 0, hs, held = 0;
        logic [DW-1:0] d;
        logic [7:0]    e;
        st    = stall_of(sel);
        limit = (nexp != 0) ? nexp : stop_after;
        @(posedge clk); #1;
        start[sel] = 1'b1;
        bexp[sel]  = 32'(nexp);
        @(posedge clk); #1;
        start[sel] = 1'b0;
        bexp[sel]  = $urandom;
        while (k < limit && cyc < 20000) begin
            tvalid[sel] = held ? 1'b1 : (($urandom % 100) < 32'(pct));
            tdata[sel]  = beat_data(k);
            if (k == restart_at) begin
                start[sel] = 1'b1;
                bexp[sel]  = 32'd3;
            end
            @(negedge clk);
            if (st != 0) check($sformatf("%s.thr_c%0d", name, cyc), 32'(tready[sel]),
                               32'((cyc % st) != st - 1));
            else check($sformatf("%s.rdy_c%0d", name, cyc), 32'(tready[sel]), 1);
            hs = tvalid[sel] && tready[sel];
            @(posedge clk); #1;
            start[sel] = 1'b0;
            if (hs) begin
                d = tdata[sel];
                e = 8'((k + 1) % 256);
                for (int l = 0; l < NB; l++) begin
                    if (d[8*l +: 8] != e) begin
                        if (!seen) begin
                            seen = 1; fbeat = k; flane = l; fdata = int'(d[8*l +: 8]);
                        end
                    end
                end
                for (int l = 0; l < NB; l++) begin
                    if (d[8*l +: 8] != e) begin
                        errs++;
                        break;
                    end
                end
                k++;
                check($sformatf("%s.bc_k%0d", name, k), bc[sel], 32'(k));
            end
            held = tvalid[sel] && !hs;
            cyc++;
            if (reset_at > 0 && k == reset_at) break;
        end
        tvalid[sel] = 1'b0;
        check($sformatf("%s.no_timeout", name), 32'(cyc < 20000), 1);
        if (pct == 100 && st == 0 && reset_at == 0)
            check($sformatf("%s.cycles", name), 32'(cyc), 32'(limit));
        if (reset_at > 0) begin
            resetn = 1'b0;
            @(posedge clk); #1;
            check_idle_zero(0, $sformatf("%s.rst0", name));
            check_idle_zero(1, $sformatf("%s.rst1", name));
            resetn = 1'b1;
            return;
        end
        if (nexp != 0) begin
            check($sformatf("%s.drain_rdy", name), 32'(tready[sel]), 0);
            check($sformatf("%s.drain_done", name), 32'(done[sel]), 0);
            @(posedge clk); #1;
            check($sformatf("%s.done", name), 32'(done[sel]), 1);
            check($sformatf("%s.pass", name), 32'(pass[sel]), 32'(errs == 0));
        end else begin
            repeat (5) @(posedge clk);
            #1;
            check($sformatf("%s.free_done", name), 32'(done[sel]), 0);
        end
        check($sformatf("%s.beats", name), bc[sel], 32'(k));
        check($sformatf("%s.errs", name), ec[sel], 32'(errs));
        check($sformatf("%s.feb", name), feb[sel], 32'(fbeat));
        check($sformatf("%s.fel", name), 32'(fel[sel]), 32'(flane));
        check($sformatf("%s.fed", name), 32'(fed[sel]), 32'(fdata));
    endtask

    task automatic rand_corr(input int nexp, input int n);
        corr_t c;
        corr.delete();
        for (int i = 0; i < n; i++) begin
            c.beat = int'($urandom % 32'(nexp));
            c.lane = int'($urandom % NB);
            c.val  = 8'($urandom);
            corr.push_back(c);
        end
    endtask

    initial begin
        corr_t c;
        resetn = 1'b0;
        start  = '0;
        bexp   = '0;
        tdata  = '0;
        tvalid = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero(0, "reset0");
        check_idle_zero(1, "reset1");
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_zero(0, "idle0");
        check_idle_zero(1, "idle1");
        tvalid = 2'b00;

        corr.delete();
        do_run(0, 300, 100, 0, -1, 0, "clean");

        corr.delete();
        c.beat = 3; c.lane = 5; c.val = 8'h00; corr.push_back(c);
        for (int l = 0; l < NB; l++) begin
            c.beat = 7; c.lane = l; c.val = 8'hAA; corr.push_back(c);
        end
        do_run(0, 10, 100, 0, -1, 0, "corrupt");

        corr.delete();
        do_run(1, 12, 100, 0, -1, 0, "bp");

        for (int r = 0; r < 4; r++) begin
            int n;
            n = 20 + int'($urandom % 60);
            rand_corr(n, int'($urandom % 4));
            do_run(r % 2, n, 40 + int'($urandom % 61), 0, n / 2, 0, $sformatf("rand%0d", r));
        end

        corr.delete();
        c.beat = 4; c.lane = 0; c.val = 8'hEE; corr.push_back(c);
        do_run(0, 50, 100, 0, -1, 5, "midrst");
        corr.delete();
        do_run(0, 4, 100, 0, -1, 0, "after_rst");

        corr.delete();
        do_run(0, 0, 100, 1000, -1, 0, "free");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
